// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier. It retires one multiplier bit on each enabled cycle.
// The product register is written only when a multiplication completes or on reset.
module seq_multiplier #(
    parameter int BIT_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   enable,
    input  logic [BIT_LEN-1:0]     factor1,
    input  logic [BIT_LEN-1:0]     factor2,
    output logic [2*BIT_LEN-1:0]   product
);

    localparam int PW = 2 * BIT_LEN;
    localparam int CW = $clog2(BIT_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [PW-1:0]      mcand_q,   mcand_d;
    logic [BIT_LEN-1:0] mplier_q,  mplier_d;
    logic [PW-1:0]      acc_q,     acc_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic [PW-1:0]      sum;

    // Accumulator plus the conditional partial product for this iteration.
    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        if (load) begin
            state_d  = RUN;
            mcand_d  = {{BIT_LEN{1'b0}}, factor1};
            mplier_d = factor2;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == RUN && enable) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // The last iteration publishes the final sum directly, so no partial value is ever visible.
            if (cnt_q == CW'(BIT_LEN - 1)) begin
                product_d = sum;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed scenarios followed by randomized traffic.
// Every output is compared against a transaction-level reference model.
module tb_seq_multiplier;

    localparam int BIT_LEN = 4;
    localparam int PW      = 2 * BIT_LEN;

    logic               clk = 1'b0;
    logic               reset;
    logic               load;
    logic               enable;
    logic [BIT_LEN-1:0] factor1;
    logic [BIT_LEN-1:0] factor2;
    logic [PW-1:0]      product;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the pending operation and the number of enabled edges it still needs.
    logic          m_busy;
    int            m_left;
    int unsigned   m_a, m_b;
    logic [PW-1:0] m_prod;

    seq_multiplier #(.BIT_LEN(BIT_LEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .enable  (enable),
        .factor1 (factor1),
        .factor2 (factor2),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: product=%0d expected=%0d at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_left = 0;
        m_a    = 0;
        m_b    = 0;
        m_prod = '0;
    endtask

    // Drive one cycle of inputs, advance the model at the rising edge, then compare.
    task automatic step(input logic ld, input logic en, input logic [BIT_LEN-1:0] a,
                        input logic [BIT_LEN-1:0] b, input string tag);
        @(negedge clk);
        load    = ld;
        enable  = en;
        factor1 = a;
        factor2 = b;
        @(posedge clk);
        if (ld) begin
            m_busy = 1'b1;
            m_left = BIT_LEN;
            m_a    = a;
            m_b    = b;
        end else if (m_busy && en) begin
            m_left--;
            if (m_left == 0) begin
                m_prod = PW'(m_a * m_b);
                m_busy = 1'b0;
            end
        end
        #1 check_eq(tag, product, m_prod);
    endtask

    task automatic run_cycles(input int n, input logic en, input string tag);
        for (int i = 0; i < n; i++)
            step(1'b0, en, BIT_LEN'($urandom), BIT_LEN'($urandom), tag);
    endtask

    // Reset asserted between clock edges must clear product immediately.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq(tag, product, m_prod);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        enable  = 1'b0;
        factor1 = '0;
        factor2 = '0;
        model_reset();
        #2 check_eq("reset_state", product, '0);
        @(negedge clk);
        reset = 1'b0;
        run_cycles(2, 1'b1, "reset_hold");

        // Basic: 2 x 1
        step(1'b1, 1'b1, 4'd2, 4'd1, "basic_load");
        run_cycles(BIT_LEN, 1'b1, "basic_run");
        check_eq("basic_result", product, 8'h02);
        run_cycles(2, 1'b1, "basic_hold");

        // Load pulse that never spans a rising edge is ignored
        @(negedge clk);
        factor1 = 4'd2;
        factor2 = 4'd2;
        #2 load = 1'b1;
        #2 load = 1'b0;
        run_cycles(BIT_LEN + 1, 1'b1, "missed_load");
        check_eq("missed_load_result", product, 8'h02);

        // Max operands; the previous value holds until completion
        step(1'b1, 1'b1, 4'd15, 4'd15, "max_load");
        run_cycles(BIT_LEN - 1, 1'b1, "max_run");
        check_eq("max_no_partial", product, 8'h02);
        run_cycles(1, 1'b1, "max_done");
        check_eq("max_result", product, 8'd225);

        // Stall in the middle of a multiplication
        step(1'b1, 1'b1, 4'd3, 4'd5, "stall_load");
        run_cycles(2, 1'b1, "stall_pre");
        run_cycles(3, 1'b0, "stall_hold");
        check_eq("stall_unchanged", product, 8'd225);
        run_cycles(2, 1'b1, "stall_post");
        check_eq("stall_result", product, 8'd15);

        // Restart with a zero multiplicand; 63 must never appear
        step(1'b1, 1'b1, 4'd7, 4'd9, "restart_load1");
        run_cycles(2, 1'b1, "restart_pre");
        step(1'b1, 1'b1, 4'd0, 4'd13, "restart_load2");
        run_cycles(BIT_LEN - 1, 1'b1, "restart_run");
        check_eq("restart_no_partial", product, 8'd15);
        run_cycles(1, 1'b1, "restart_done");
        check_eq("zero_result", product, 8'd0);

        // Reset during RUN aborts the operation
        step(1'b1, 1'b1, 4'd5, 4'd6, "abort_load");
        run_cycles(2, 1'b1, "abort_pre");
        mid_reset("abort_reset");
        run_cycles(BIT_LEN + 2, 1'b1, "abort_after");
        check_eq("abort_result", product, 8'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0)
                mid_reset("rand_reset");
            else
                step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                     BIT_LEN'($urandom), BIT_LEN'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Unsigned sequential shift-and-add multiplier. It processes one multiplier bit per enabled clock cycle.
- A `load` pulse captures both operands.
- After BIT_LEN enabled cycles, the full 2*BIT_LEN-bit product is written to a registered output.
- The output holds that value until the next result completes.

It is a small arithmetic datapath block used wherever a low-area, multi-cycle multiply is acceptable.

Parameters:
- BIT_LEN, 4, operand width in bits; product width is 2*BIT_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  when high at a rising edge, captures operands and starts a new multiplication.
- enable  input  1  when high, the active multiplication advances one iteration per rising edge.
- factor1  input  BIT_LEN  multiplicand, unsigned.
- factor2  input  BIT_LEN  multiplier, unsigned.
- product  output  2*BIT_LEN  registered result of the last completed multiplication.

Behaviour:
- Reset (asynchronous, active-high):
  - product = 0; accumulator = 0; operand registers = 0; iteration counter = 0; busy = 0.
  - Reset is effective immediately and overrides everything.
  - Reset mid-operation aborts the operation; product reads 0.
- Internal state:
  - busy flag.
  - Multiplicand register, 2*BIT_LEN bits, zero-extended factor1.
  - Multiplier register, BIT_LEN bits.
  - Accumulator, 2*BIT_LEN bits.
  - Iteration counter, clog2(BIT_LEN+1) bits.
- States: IDLE (busy=0) and RUN (busy=1).
- Load (sampled only at the rising edge; a pulse that does not span a rising edge is ignored):
  - multiplicand <= {0, factor1}; multiplier <= factor2; accumulator <= 0; counter <= 0; busy <= 1.
  - product is NOT changed.
  - Load is accepted regardless of enable.
  - Load takes priority over an iteration in the same cycle.
  - Load while busy aborts the current operation and restarts with the new operands; the old result is discarded.
- Iteration (busy=1, enable=1, load=0) at each rising edge:
  - If multiplier[0] = 1: accumulator <= accumulator + multiplicand (mod 2^(2*BIT_LEN); cannot overflow).
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - On the iteration where counter reaches BIT_LEN:
    - product <= the updated accumulator value (i.e., accumulator + conditional add, computed combinationally);
    - busy <= 0.
- Stall: busy=1 and enable=0 → all state holds; the iteration count does not advance.
- IDLE with load=0: all state holds; product keeps the last result.
- Latency: load edge L; the result is visible on product after the BIT_LEN-th subsequent enabled rising edge. With enable held high, product is valid after edge L+BIT_LEN.
- product never shows partial sums; it changes only on completion or reset.
- Operands are captured at load, so factor1/factor2 may change freely afterwards without affecting the result.
- Boundaries:
  - 0 × x = 0 (still takes BIT_LEN cycles and updates product to 0).
  - Maximum (2^BIT_LEN-1)^2 fits exactly in 2*BIT_LEN bits.

Test Plan:
- Reset: assert reset mid-cycle → product = 0 immediately; deassert → product stays 0 with load=0.
- Basic (BIT_LEN=4, enable=1): factor1=2, factor2=1, load high across one rising edge → product = 8'h02 after 4 further rising edges, and unchanged thereafter.
- Missed load: load pulse that rises and falls between clock edges (operands 2, 2) → product stays 8'h02.
- Max operands: factor1=15, factor2=15, load for one edge, enable=1 → product = 8'd225 after 4 edges; the prior value (2) is held until the completing edge, with no intermediate values.
- Stall: load 3×5, drop enable for 3 cycles after 2 iterations → product = 15 only after 4 enabled edges total; no change while stalled.
- Restart and zero:
  - Load 7×9, then load 0×13 after 2 iterations → product = 0 after 4 edges from the second load; 63 never appears.
  - Reset during RUN → product = 0 and no later completion occurs.
